seq_checker: RTL and testbench



---
 rtl/seq_pkg.sv | 19 +
 rtl/sat_counter.sv | 23 ++
 rtl/seq_checker.sv | 135 +++++++++++++
 tb/tb_seq_checker.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-counter checker: FSM encodings, default
// stream parameters and a small sizing helper.
package seq_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_STEP  = 1;

    // Bits needed to hold values 0..n inclusive.
    function automatic int cnt_bits(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones, and a clear
// coinciding with an increment restarts the count at one.
module sat_counter #(
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            clr,
    output logic [ERRW-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? ERRW'(1) : '0;
        end else if (inc && (count != {ERRW{1'b1}})) begin
            count <= count + ERRW'(1);
        end
    end

endmodule

// File: rtl/seq_checker.sv
// Receive-side checker for a modulo-2^WIDTH sequence stream: acquires lock on a
// run of in-sequence samples and flags every break while locked.
module seq_checker
    import seq_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int STEP     = DEF_STEP,
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 2,
    parameter int ERRW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] countreg,
    input  logic             clr_err,
    output logic             locked,
    output logic             mismatch,
    output logic [WIDTH-1:0] expected,
    output logic [ERRW-1:0]  err_count,
    output logic [1:0]       state
);

    localparam int RUNW = cnt_bits(LOCK_CNT);
    localparam int MISSW = cnt_bits(LOSS_CNT);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   expected_reg, expected_next;
    logic [RUNW-1:0]    run_reg, run_next;
    logic [MISSW-1:0]   miss_reg, miss_next;
    logic               mismatch_reg, mismatch_next;
    logic               locked_reg, locked_next;
    logic               err_inc;

    logic [WIDTH-1:0]   reseed;
    logic [RUNW-1:0]    run_plus;
    logic [MISSW-1:0]   miss_plus;
    logic               in_seq;

    assign reseed    = countreg + STEP_W;
    assign run_plus  = run_reg + RUNW'(1);
    assign miss_plus = miss_reg + MISSW'(1);
    assign in_seq    = (countreg == expected_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= HUNT;
            expected_reg <= '0;
            run_reg      <= '0;
            miss_reg     <= '0;
            mismatch_reg <= 1'b0;
            locked_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            expected_reg <= expected_next;
            run_reg      <= run_next;
            miss_reg     <= miss_next;
            mismatch_reg <= mismatch_next;
            locked_reg   <= locked_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        expected_next = expected_reg;
        run_next      = run_reg;
        miss_next     = miss_reg;
        mismatch_next = 1'b0;
        err_inc       = 1'b0;

        case (state_reg)
            HUNT: begin
                if (in_valid) begin
                    expected_next = reseed;
                    run_next      = RUNW'(1);
                    state_next    = (LOCK_CNT == 1) ? LOCKED : ACQ;
                end
            end
            ACQ: begin
                if (in_valid) begin
                    expected_next = reseed;
                    if (in_seq) begin
                        run_next = run_plus;
                        if (run_plus == RUNW'(LOCK_CNT)) begin
                            state_next = LOCKED;
                        end
                    end else begin
                        run_next = RUNW'(1);
                    end
                end
            end
            LOCKED: begin
                if (in_valid) begin
                    // Flywheel: the prediction advances whether or not the sample matched.
                    expected_next = expected_reg + STEP_W;
                    if (in_seq) begin
                        miss_next = '0;
                    end else begin
                        mismatch_next = 1'b1;
                        err_inc       = 1'b1;
                        miss_next     = miss_plus;
                        if (miss_plus == MISSW'(LOSS_CNT)) begin
                            state_next    = ACQ;
                            expected_next = reseed;
                            run_next      = RUNW'(1);
                            miss_next     = '0;
                        end
                    end
                end
            end
            default: begin
                state_next = HUNT;
            end
        endcase

        locked_next = (state_next == LOCKED);
    end

    sat_counter #(
        .ERRW (ERRW)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (err_inc),
        .clr   (clr_err),
        .count (err_count)
    );

    assign locked   = locked_reg;
    assign mismatch = mismatch_reg;
    assign expected = expected_reg;
    assign state    = state_reg;

endmodule

// File: tb/tb_seq_checker.sv
// Self-checking bench for seq_checker: directed scenarios plus a randomized
// stream compared against a behavioural model of the checking rules.
module tb_seq_checker;

    localparam int WIDTH    = 3;
    localparam int STEP     = 1;
    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 2;
    localparam int MOD      = 1 << WIDTH;
    localparam int MAX8     = 255;
    localparam int MAX2     = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] countreg = '0;
    logic             clr_err = 1'b0;

    logic             locked, mismatch;
    logic [WIDTH-1:0] expected;
    logic [7:0]       err_count;
    logic [1:0]       state;

    logic             s_locked, s_mismatch;
    logic [WIDTH-1:0] s_expected;
    logic [1:0]       s_err;
    logic [1:0]       s_state;

    int checks = 0;
    int failures = 0;

    // Model state: 0=hunting, 1=acquiring, 2=locked
    int m_state, m_exp, m_run, m_miss, m_err, m_errs, m_mm;

    seq_checker #(.WIDTH(WIDTH), .STEP(STEP), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERRW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .countreg(countreg), .clr_err(clr_err),
        .locked(locked), .mismatch(mismatch), .expected(expected), .err_count(err_count), .state(state)
    );

    seq_checker #(.WIDTH(WIDTH), .STEP(STEP), .LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .ERRW(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .countreg(countreg), .clr_err(clr_err),
        .locked(s_locked), .mismatch(s_mismatch), .expected(s_expected), .err_count(s_err), .state(s_state)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_exp = 0; m_run = 0; m_miss = 0; m_err = 0; m_errs = 0; m_mm = 0;
    endtask

    task automatic model_edge(input logic v, input int val, input logic c);
        int inc;
        inc = 0;
        if (v) begin
            if (m_state == 0) begin
                m_exp = (val + STEP) % MOD;
                m_run = 1;
                m_state = (LOCK_CNT == 1) ? 2 : 1;
            end else if (m_state == 1) begin
                if (val == m_exp) begin
                    m_run = m_run + 1;
                    if (m_run == LOCK_CNT) m_state = 2;
                end else begin
                    m_run = 1;
                end
                m_exp = (val + STEP) % MOD;
            end else begin
                m_exp = (m_exp + STEP) % MOD;
                if (val == (m_exp + MOD - STEP) % MOD) begin
                    m_miss = 0;
                end else begin
                    inc = 1;
                    m_miss = m_miss + 1;
                    if (m_miss == LOSS_CNT) begin
                        m_state = 1;
                        m_exp = (val + STEP) % MOD;
                        m_run = 1;
                        m_miss = 0;
                    end
                end
            end
        end
        if (c) begin
            m_err = inc;
            m_errs = inc;
        end else if (inc == 1) begin
            if (m_err < MAX8) m_err = m_err + 1;
            if (m_errs < MAX2) m_errs = m_errs + 1;
        end
        m_mm = inc;
    endtask

    task automatic step(input logic v, input int val, input logic c);
        in_valid = v;
        countreg = WIDTH'(val % MOD);
        clr_err = c;
        @(posedge clk);
        model_edge(v, val % MOD, c);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0; clr_err = 1'b0; countreg = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic lock_up();
        for (int i = 0; i < LOCK_CNT; i++) step(1'b1, i, 1'b0);
    endtask

    task automatic test_reset();
        in_valid = 1'b1; countreg = 3'd5; clr_err = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (state !== 2'd0 || locked !== 1'b0 || mismatch !== 1'b0 || expected !== 3'd0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_values: state=%0d locked=%0b mismatch=%0b expected=%0d err=%0d required all 0",
                     state, locked, mismatch, expected, err_count);
        end
        rst = 1'b1;
        in_valid = 1'b0;
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < LOCK_CNT; i++) begin
            step(1'b1, i, 1'b0);
            checks++;
            if (mismatch !== 1'b0) begin
                failures++;
                $display("FAIL lock_no_mismatch: edge %0d mismatch=%0b required 0", i + 1, mismatch);
            end
            if (i == LOCK_CNT - 2) begin
                checks++;
                if (locked !== 1'b0) begin
                    failures++;
                    $display("FAIL lock_early: locked=%0b after edge %0d required 0", locked, i + 1);
                end
            end
        end
        checks++;
        if (locked !== 1'b1 || expected !== 3'd4 || err_count !== 8'd0 || state !== 2'd2) begin
            failures++;
            $display("FAIL lock_acquired: locked=%0b expected=%0d err=%0d state=%0d required 1,4,0,2",
                     locked, expected, err_count, state);
        end
        $display("test_lock done");
    endtask

    task automatic test_wrap();
        int vals[4] = '{6, 7, 0, 1};
        int exps[4] = '{7, 0, 1, 2};
        do_reset();
        lock_up();
        step(1'b1, 4, 1'b0);
        step(1'b1, 5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vals[i], 1'b0);
            checks++;
            if (mismatch !== 1'b0 || int'(expected) != exps[i] || locked !== 1'b1) begin
                failures++;
                $display("FAIL wrap: sample %0d mismatch=%0b expected=%0d locked=%0b required 0,%0d,1",
                         vals[i], mismatch, expected, locked, exps[i]);
            end
        end
        $display("test_wrap done");
    endtask

    task automatic test_glitch();
        int vals[5] = '{2, 3, 5, 5, 6};
        logic mm[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        lock_up();
        for (int v = 4; v < 10; v++) step(1'b1, v, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, vals[i], 1'b0);
            checks++;
            if (mismatch !== mm[i] || locked !== 1'b1) begin
                failures++;
                $display("FAIL glitch: sample %0d mismatch=%0b locked=%0b required %0b,1",
                         vals[i], mismatch, locked, mm[i]);
            end
        end
        checks++;
        if (err_count !== 8'd1 || expected !== 3'd7) begin
            failures++;
            $display("FAIL glitch_count: err=%0d expected=%0d required 1,7", err_count, expected);
        end
        $display("test_glitch done");
    endtask

    task automatic test_loss();
        do_reset();
        lock_up();
        step(1'b1, 4, 1'b0);
        for (int i = 0; i < LOSS_CNT; i++) begin
            step(1'b1, 0, 1'b0);
            checks++;
            if (mismatch !== 1'b1) begin
                failures++;
                $display("FAIL loss_pulse: miss %0d mismatch=%0b required 1", i + 1, mismatch);
            end
        end
        checks++;
        if (locked !== 1'b0 || state !== 2'd1 || err_count !== 8'd2 || expected !== 3'd1) begin
            failures++;
            $display("FAIL loss_state: locked=%0b state=%0d err=%0d expected=%0d required 0,1,2,1",
                     locked, state, err_count, expected);
        end
        for (int v = 1; v < LOCK_CNT; v++) begin
            step(1'b1, v, 1'b0);
            checks++;
            if (mismatch !== 1'b0 || locked !== (v == LOCK_CNT - 1)) begin
                failures++;
                $display("FAIL relock: sample %0d mismatch=%0b locked=%0b required 0,%0b",
                         v, mismatch, locked, (v == LOCK_CNT - 1));
            end
        end
        $display("test_loss done");
    endtask

    task automatic test_saturation();
        int e;
        do_reset();
        lock_up();
        e = 4;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, (e + 3) % MOD, 1'b0);
            e = (e + 1) % MOD;
            step(1'b1, e, 1'b0);
            e = (e + 1) % MOD;
        end
        checks++;
        if (s_err !== 2'd3 || err_count !== 8'd5 || locked !== 1'b1) begin
            failures++;
            $display("FAIL saturate: err2=%0d err8=%0d locked=%0b required 3,5,1", s_err, err_count, locked);
        end
        step(1'b1, (e + 3) % MOD, 1'b1);
        checks++;
        if (s_err !== 2'd1 || err_count !== 8'd1 || mismatch !== 1'b1) begin
            failures++;
            $display("FAIL clr_with_inc: err2=%0d err8=%0d mismatch=%0b required 1,1,1", s_err, err_count, mismatch);
        end
        step(1'b0, 0, 1'b1);
        checks++;
        if (s_err !== 2'd0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL clr_alone: err2=%0d err8=%0d required 0,0", s_err, err_count);
        end
        $display("test_saturation done");
    endtask

    task automatic test_gap();
        do_reset();
        lock_up();
        step(1'b1, 7, 1'b0);
        checks++;
        if (mismatch !== 1'b1) begin
            failures++;
            $display("FAIL gap_pre: mismatch=%0b required 1", mismatch);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, int'($urandom_range(0, 7)), 1'b0);
            checks++;
            if (mismatch !== 1'b0 || locked !== 1'b1 || expected !== 3'd5 || err_count !== 8'd1 || state !== 2'd2) begin
                failures++;
                $display("FAIL gap_hold: cycle %0d mismatch=%0b locked=%0b expected=%0d err=%0d state=%0d required 0,1,5,1,2",
                         i, mismatch, locked, expected, err_count, state);
            end
        end
        // The held miss count means one more mismatch drops lock.
        step(1'b1, 0, 1'b0);
        checks++;
        if (mismatch !== 1'b1 || locked !== 1'b0 || state !== 2'd1 || err_count !== 8'd2) begin
            failures++;
            $display("FAIL gap_miss_held: mismatch=%0b locked=%0b state=%0d err=%0d required 1,0,1,2",
                     mismatch, locked, state, err_count);
        end
        $display("test_gap done");
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 0, 1'b0);
        step(1'b1, 1, 1'b0);
        checks++;
        if (state !== 2'd1 || expected !== 3'd2) begin
            failures++;
            $display("FAIL async_pre: state=%0d expected=%0d required 1,2", state, expected);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || locked !== 1'b0 || mismatch !== 1'b0 || expected !== 3'd0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL async_reset: state=%0d locked=%0b mismatch=%0b expected=%0d err=%0d required all 0",
                     state, locked, mismatch, expected, err_count);
        end
        model_reset();
        #2;
        rst = 1'b1;
        step(1'b0, 0, 1'b0);
        checks++;
        if (state !== 2'd0 || expected !== 3'd0) begin
            failures++;
            $display("FAIL async_release: state=%0d expected=%0d required 0,0", state, expected);
        end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        int src, val;
        logic v, c;
        do_reset();
        src = int'($urandom_range(0, 7));
        for (int n = 0; n < 800; n++) begin
            v = ($urandom_range(0, 9) < 8);
            val = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : src;
            c = ($urandom_range(0, 49) == 0);
            step(v, val, c);
            if (v) src = (src + STEP) % MOD;
            if ($urandom_range(0, 99) == 0) src = int'($urandom_range(0, 7));
            checks++;
            if (int'(state) != m_state || locked !== (m_state == 2) || int'(expected) != m_exp ||
                int'(mismatch) != m_mm || int'(err_count) != m_err || int'(s_err) != m_errs) begin
                failures++;
                $display("FAIL random: cycle %0d state=%0d/%0d locked=%0b expected=%0d/%0d mismatch=%0b/%0d err=%0d/%0d err2=%0d/%0d (got/required)",
                         n, state, m_state, locked, expected, m_exp, mismatch, m_mm, err_count, m_err, s_err, m_errs);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_wrap();
        test_glitch();
        test_loss();
        test_saturation();
        test_gap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
